// File: rtl/det_seq_pkg.sv
// Shared definitions for the serial pattern-detector sequencer.
package det_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    // Bits needed to encode values 0..v-1.
    function automatic int unsigned clog2_u(input int unsigned v);
        return int'($clog2(v));
    endfunction

endpackage

// File: rtl/det_seq_ctrl_piso_shreg.sv
// Parallel-load, shift-left register exposing its MSB for serialisation.
module piso_shreg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = din;
        end else if (shift) begin
            data_d = {data_q[WIDTH-2:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign msb = data_q[WIDTH-1];

endmodule

// File: rtl/det_seq_ctrl.sv
// Sequencer: clears the detector, shifts a word into it MSB first and
// collects hit count and first-hit index from its Moore output.
module det_seq_ctrl
    import det_seq_pkg::*;
#(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = clog2_u(WIDTH + 1),
    localparam int unsigned IDX_W = clog2_u(WIDTH)
) (
    input  logic             clk,
    input  logic             Re,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic             det_rst,
    output logic             det_w,
    input  logic             det_z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] hits,
    output logic             found,
    output logic [IDX_W-1:0] first_idx
);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] hits_q, hits_d;
    logic             found_q, found_d;
    logic [IDX_W-1:0] first_idx_q, first_idx_d;

    logic             load;
    logic             shift;
    logic             sample;
    logic [IDX_W-1:0] sample_idx;
    logic             sr_msb;

    piso_shreg #(.WIDTH(WIDTH)) u_shreg (
        .clk   (clk),
        .rst   (Re),
        .load  (load),
        .shift (shift),
        .din   (pattern),
        .msb   (sr_msb)
    );

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        hits_d      = hits_q;
        found_d     = found_q;
        first_idx_d = first_idx_q;
        load        = 1'b0;
        shift       = 1'b0;
        sample      = 1'b0;
        sample_idx  = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    load        = 1'b1;
                    hits_d      = '0;
                    found_d     = 1'b0;
                    first_idx_d = '0;
                    state_d     = S_CLEAR;
                end
            end
            S_CLEAR: begin
                k_d     = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                shift = 1'b1;
                // z seen at k reflects the bit driven at k-1; k=0 still shows reset
                if (k_q != '0) begin
                    sample     = 1'b1;
                    sample_idx = k_q - IDX_W'(1);
                end
                if (k_q == IDX_W'(WIDTH - 1)) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                sample     = 1'b1;
                sample_idx = IDX_W'(WIDTH - 1);
                state_d    = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (sample && det_z) begin
            hits_d = hits_q + CNT_W'(1);
            if (!found_q) begin
                found_d     = 1'b1;
                first_idx_d = sample_idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (Re) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            hits_q      <= '0;
            found_q     <= 1'b0;
            first_idx_q <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            hits_q      <= hits_d;
            found_q     <= found_d;
            first_idx_q <= first_idx_d;
        end
    end

    assign det_rst   = Re | (state_q == S_CLEAR);
    assign det_w     = (state_q == S_SHIFT) & sr_msb;
    assign busy      = (state_q == S_CLEAR) | (state_q == S_SHIFT) | (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);
    assign hits      = hits_q;
    assign found     = found_q;
    assign first_idx = first_idx_q;

endmodule

// File: tb/tb_det_seq_ctrl.sv
// Directed bench for det_seq_ctrl with a one-flop detector model (z <= w).
module tb_det_seq_ctrl;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned IDX_W = 3;

    logic             clk;
    logic             Re;
    logic             start;
    logic [WIDTH-1:0] pattern;
    logic             det_rst;
    logic             det_w;
    logic             det_z;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] hits;
    logic             found;
    logic [IDX_W-1:0] first_idx;

    int n_tests = 0;
    int n_fail  = 0;

    det_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .Re        (Re),
        .start     (start),
        .pattern   (pattern),
        .det_rst   (det_rst),
        .det_w     (det_w),
        .det_z     (det_z),
        .busy      (busy),
        .done      (done),
        .hits      (hits),
        .found     (found),
        .first_idx (first_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Detector stand-in: z follows w one cycle later, cleared by det_rst.
    always @(posedge clk) det_z <= det_rst ? 1'b0 : det_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run; pattern is scrambled and start pulsed mid-run, both must be ignored.
    task automatic do_run(input logic [7:0] p, input int eh, input int ef, input int ei);
        start   = 1'b1;
        pattern = p;
        tick();
        start   = 1'b0;
        pattern = ~p;
        check("clear_det_rst", det_rst, 1);
        check("clear_busy", busy, 1);
        check("clear_det_w", det_w, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i == 2) start = 1'b1;
            if (i == 5) start = 1'b0;
            check($sformatf("shift_w[%0d]", i), det_w, p[7-i]);
            check($sformatf("shift_rst[%0d]", i), det_rst, 0);
        end
        tick();
        check("drain_w", det_w, 0);
        check("drain_busy", busy, 1);
        check("drain_done", done, 0);
        tick();
        check("done_pulse", done, 1);
        check("done_busy", busy, 0);
        check("hits", hits, eh);
        check("found", found, ef);
        check("first_idx", first_idx, ei);
        tick();
        check("done_clr", done, 0);
        check("idle_busy", busy, 0);
        check("hits_hold", hits, eh);
        check("found_hold", found, ef);
        check("first_idx_hold", first_idx, ei);
    endtask

    initial begin
        int done_cnt;
        int last_done;

        Re      = 1'b1;
        start   = 1'b0;
        pattern = '0;
        tick();
        tick();
        check("rst_det_rst", det_rst, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hits", hits, 0);
        check("rst_found", found, 0);
        check("rst_first_idx", first_idx, 0);
        check("rst_det_w", det_w, 0);
        Re = 1'b0;
        tick();
        check("idle_det_rst", det_rst, 0);

        do_run(8'b1011_0010, 4, 1, 0);
        do_run(8'h00, 0, 0, 0);
        do_run(8'h01, 1, 1, 7);
        do_run(8'b0010_1100, 3, 1, 2);

        // start held for 30 cycles: runs back-to-back, done every 12 cycles
        start     = 1'b1;
        pattern   = 8'hFF;
        done_cnt  = 0;
        last_done = -1;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (c == 29) start = 1'b0;
            if (done) begin
                done_cnt++;
                check("b2b_hits", hits, 8);
                check("b2b_first_idx", first_idx, 0);
                if (last_done >= 0) check("b2b_spacing", c - last_done, 12);
                last_done = c;
            end
        end
        check("b2b_done_count", done_cnt, 3);

        // Reset mid-run at SHIFT k=3 (t+5) after two hits have been counted
        start   = 1'b1;
        pattern = 8'hF0;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        tick();
        check("pre_abort_hits", hits, 2);
        Re = 1'b1;
        #1;
        check("abort_det_rst", det_rst, 1);
        tick();
        Re = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_hits", hits, 0);
        check("abort_found", found, 0);
        check("abort_first_idx", first_idx, 0);
        done_cnt = 0;
        for (int c = 0; c < 15; c++) begin
            if (done) done_cnt++;
            tick();
        end
        check("abort_no_done", done_cnt, 0);

        do_run(8'hF0, 4, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
